// File: rtl/dtcm_lsu_if.sv
// dtcm_lsu_if: core request/response bundle plus the DTCM port driven by the LSU
interface dtcm_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wen, mem_wdata
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wen, mem_wdata
    );
endinterface

// File: rtl/dtcm_lsu.sv
// dtcm_lsu: single-outstanding load/store initiator for the data TCM
module dtcm_lsu #(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int unsigned DTCM_BYTES   = 4096,
    parameter int unsigned READ_LATENCY = 1
) (
    input logic       clk,
    input logic       reset,
    dtcm_lsu_if.slave bus
);
    typedef enum logic {IDLE, WAIT} state_t;
    state_t      state;
    logic        ready;
    logic [1:0]  cnt;
    logic [31:0] addr_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic [1:0]  off;
    logic        in_win;
    logic        err;
    logic        accept;
    logic [3:0]  wen;
    logic [31:0] shifted;
    logic [31:0] ext;

    // request decode, lane enables and load-data extraction
    always_comb begin
        off     = bus.req_addr[1:0];
        in_win  = (bus.req_addr - BASE_ADDR) < 32'(DTCM_BYTES);
        err     = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && off[0]) ||
                  (bus.req_size == 2'b10 && off != 2'b00) || !in_win;
        accept  = bus.req_valid && ready && !reset;
        wen     = bus.req_size == 2'b00 ? 4'b0001 << off :
                  bus.req_size == 2'b01 ? 4'b0011 << off : 4'b1111;
        shifted = bus.mem_rdata >> {off_q, 3'b000};
        ext     = size_q == 2'b00 ? {{24{shifted[7] & ~uns_q}}, shifted[7:0]} :
                  size_q == 2'b01 ? {{16{shifted[15] & ~uns_q}}, shifted[15:0]} : shifted;
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid;
    assign bus.rsp_err   = rsp_err;
    assign bus.rsp_rdata = rsp_rdata;
    assign bus.mem_addr  = state == WAIT ? addr_q : bus.req_addr;
    assign bus.mem_wen   = accept && !err && bus.req_we ? wen : 4'b0000;
    assign bus.mem_wdata = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
                           bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;

    // control FSM: errors and stores answer next cycle, loads wait out the read latency
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ready     <= 1'b1;
            cnt       <= 2'd0;
            addr_q    <= 32'd0;
            off_q     <= 2'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (err || bus.req_we) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= err;
                        end else begin
                            state  <= WAIT;
                            ready  <= 1'b0;
                            cnt    <= 2'(READ_LATENCY - 1);
                            addr_q <= bus.req_addr;
                            off_q  <= off;
                            size_q <= bus.req_size;
                            uns_q  <= bus.req_unsigned;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 2'd0) begin
                        state     <= IDLE;
                        ready     <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= ext;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dtcm_lsu.sv
// tb_dtcm_lsu: directed checks of dtcm_lsu at read latency 1 and 2
module tb_dtcm_lsu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    dtcm_lsu_if ia();
    dtcm_lsu_if ib();

    dtcm_lsu #(.BASE_ADDR(32'h1000_0000), .DTCM_BYTES(4096), .READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ia));
    dtcm_lsu #(.BASE_ADDR(32'h1000_0000), .DTCM_BYTES(4096), .READ_LATENCY(2)) dut_b (
        .clk(clk), .reset(reset), .bus(ib));

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] rd_a, rd_b1, rd_b2;

    // clock
    always #5 clk = ~clk;

    // DTCM model for the latency-1 instance
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ia.mem_wen[i]) mem_a[ia.mem_addr[11:2]][8*i +: 8] <= ia.mem_wdata[8*i +: 8];
        rd_a <= mem_a[ia.mem_addr[11:2]];
    end

    // DTCM model for the latency-2 instance
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ib.mem_wen[i]) mem_b[ib.mem_addr[11:2]][8*i +: 8] <= ib.mem_wdata[8*i +: 8];
        rd_b1 <= mem_b[ib.mem_addr[11:2]];
        rd_b2 <= rd_b1;
    end

    assign ia.mem_rdata = rd_a;
    assign ib.mem_rdata = rd_b2;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd);
        ia.req_valid = v; ia.req_we = we; ia.req_size = sz;
        ia.req_unsigned = uns; ia.req_addr = addr; ia.req_wdata = wd;
    endtask

    task automatic single_a(input logic we, input logic [1:0] sz, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [3:0] wen, output logic [31:0] wdo,
                            output logic rv, output logic re, output logic [31:0] rd);
        drive_a(1'b1, we, sz, 1'b0, addr, wd);
        @(negedge clk);
        wen = ia.mem_wen;
        wdo = ia.mem_wdata;
        tick;
        ia.req_valid = 1'b0;
        @(negedge clk);
        rv = ia.rsp_valid;
        re = ia.rsp_err;
        rd = ia.rsp_rdata;
        tick;
    endtask

    task automatic load_a(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                          output logic [31:0] rd, output logic re, output int lat);
        drive_a(1'b1, 1'b0, sz, uns, addr, 32'd0);
        lat = 0;
        rd = 'x;
        re = 'x;
        tick;
        ia.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ia.rsp_valid) begin
                lat = c;
                rd = ia.rsp_rdata;
                re = ia.rsp_err;
                break;
            end
            tick;
        end
        tick;
    endtask

    task automatic test_reset;
        drive_a(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        ib.req_valid = 1'b0; ib.req_we = 1'b0; ib.req_size = 2'b00;
        ib.req_unsigned = 1'b0; ib.req_addr = 32'd0; ib.req_wdata = 32'd0;
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ia.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ia.req_ready); end
        n_cmp++; if (ia.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", ia.rsp_valid); end
        n_cmp++; if (ia.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b expected 0", ia.rsp_err); end
        n_cmp++; if (ia.rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h expected 0", ia.rsp_rdata); end
        n_cmp++; if (ia.mem_wen !== 4'b0000) begin n_fail++; $display("FAIL reset_mem_wen: got %b expected 0000", ia.mem_wen); end
        n_cmp++; if (ia.mem_addr !== 32'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", ia.mem_addr); end
        n_cmp++; if (ib.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_b: got %b expected 1", ib.req_ready); end
        tick;
    endtask

    task automatic test_store_load_word;
        logic [3:0] wen; logic [31:0] wd, rd; logic rv, re; int lat;
        single_a(1'b1, 2'b10, 32'h1000_0010, 32'hDEAD_BEEF, wen, wd, rv, re, rd);
        n_cmp++; if (wen !== 4'b1111) begin n_fail++; $display("FAIL sw_wen: got %b expected 1111", wen); end
        n_cmp++; if (wd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_wdata: got %h expected deadbeef", wd); end
        n_cmp++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL sw_rsp: got valid %b err %b expected 1 0", rv, re); end
        n_cmp++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sw_rdata: got %h expected 0", rd); end
        load_a(2'b10, 1'b0, 32'h1000_0010, rd, re, lat);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", rd); end
        n_cmp++; if (re !== 1'b0) begin n_fail++; $display("FAIL lw_err: got %b expected 0", re); end
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    endtask

    task automatic test_load_extend;
        logic [3:0] wen; logic [31:0] wd, rd; logic rv, re; int lat;
        logic [31:0] addrs [6] = '{32'h1000_0023, 32'h1000_0023, 32'h1000_0021, 32'h1000_0022, 32'h1000_0022, 32'h1000_0020};
        logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        logic        unss  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] exps  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_8081, 32'h0000_8081, 32'h0000_7F01};
        single_a(1'b1, 2'b10, 32'h1000_0020, 32'h8081_7F01, wen, wd, rv, re, rd);
        for (int k = 0; k < 6; k++) begin
            load_a(sizes[k], unss[k], addrs[k], rd, re, lat);
            n_cmp++; if (rd !== exps[k] || re !== 1'b0 || lat !== 2) begin
                n_fail++; $display("FAIL load_ext_%0d: got %h err %b lat %0d expected %h err 0 lat 2", k, rd, re, lat, exps[k]);
            end
        end
    endtask

    task automatic test_store_lanes;
        logic [3:0] wen; logic [31:0] wd, rd; logic rv, re; int lat;
        single_a(1'b1, 2'b00, 32'h1000_0003, 32'h0000_00A5, wen, wd, rv, re, rd);
        n_cmp++; if (wen !== 4'b1000) begin n_fail++; $display("FAIL sb_wen: got %b expected 1000", wen); end
        n_cmp++; if (wd !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_wdata: got %h expected a5a5a5a5", wd); end
        n_cmp++; if (rv !== 1'b1 || re !== 1'b0) begin n_fail++; $display("FAIL sb_rsp: got valid %b err %b expected 1 0", rv, re); end
        load_a(2'b00, 1'b1, 32'h1000_0003, rd, re, lat);
        n_cmp++; if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL lbu_a5: got %h expected 000000a5", rd); end
        single_a(1'b1, 2'b01, 32'h1000_0002, 32'h0000_1234, wen, wd, rv, re, rd);
        n_cmp++; if (wen !== 4'b1100) begin n_fail++; $display("FAIL sh_wen: got %b expected 1100", wen); end
        n_cmp++; if (wd !== 32'h1234_1234) begin n_fail++; $display("FAIL sh_wdata: got %h expected 12341234", wd); end
        load_a(2'b01, 1'b1, 32'h1000_0002, rd, re, lat);
        n_cmp++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL lhu_1234: got %h expected 00001234", rd); end
        load_a(2'b00, 1'b0, 32'h1000_0003, rd, re, lat);
        n_cmp++; if (rd !== 32'h0000_0012) begin n_fail++; $display("FAIL lb_12: got %h expected 00000012", rd); end
    endtask

    task automatic test_errors;
        logic [3:0] wen; logic [31:0] wd, rd; logic rv, re; int lat;
        logic        wes   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  sizes [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
        logic [31:0] addrs [6] = '{32'h1000_0002, 32'h1000_0001, 32'h1000_0000, 32'h1000_1000, 32'h1000_0012, 32'h0FFF_FFFC};
        for (int k = 0; k < 6; k++) begin
            single_a(wes[k], sizes[k], addrs[k], 32'h1111_1111, wen, wd, rv, re, rd);
            n_cmp++; if (wen !== 4'b0000 || rv !== 1'b1 || re !== 1'b1 || rd !== 32'd0) begin
                n_fail++; $display("FAIL err_%0d: got wen %b valid %b err %b rdata %h expected 0000 1 1 0", k, wen, rv, re, rd);
            end
        end
        load_a(2'b10, 1'b0, 32'h1000_0010, rd, re, lat);
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL err_no_write: got %h expected deadbeef", rd); end
        single_a(1'b1, 2'b10, 32'h1000_0FFC, 32'hCAFE_F00D, wen, wd, rv, re, rd);
        n_cmp++; if (wen !== 4'b1111 || rv !== 1'b1 || re !== 1'b0) begin
            n_fail++; $display("FAIL top_word_store: got wen %b valid %b err %b expected 1111 1 0", wen, rv, re);
        end
        load_a(2'b10, 1'b0, 32'h1000_0FFC, rd, re, lat);
        n_cmp++; if (rd !== 32'hCAFE_F00D || re !== 1'b0 || lat !== 2) begin
            n_fail++; $display("FAIL top_word_load: got %h err %b lat %0d expected cafef00d 0 2", rd, re, lat);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd; logic re; int lat;
        int pulses = 0;
        for (int k = 0; k < 4; k++) begin
            drive_a(1'b1, 1'b1, 2'b10, 1'b0, 32'h1000_0080 + 32'(4 * k), 32'hB0B0_0000 + 32'(k));
            @(negedge clk);
            n_cmp++; if (ia.req_ready !== 1'b1 || ia.mem_wen !== 4'b1111) begin
                n_fail++; $display("FAIL b2b_accept_%0d: got ready %b wen %b expected 1 1111", k, ia.req_ready, ia.mem_wen);
            end
            if (ia.rsp_valid === 1'b1 && ia.rsp_err === 1'b0) pulses++;
            tick;
        end
        ia.req_valid = 1'b0;
        @(negedge clk);
        if (ia.rsp_valid === 1'b1 && ia.rsp_err === 1'b0) pulses++;
        tick;
        @(negedge clk);
        n_cmp++; if (pulses !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
        n_cmp++; if (ia.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_pulse: got %b expected 0", ia.rsp_valid); end
        tick;
        load_a(2'b10, 1'b0, 32'h1000_008C, rd, re, lat);
        n_cmp++; if (rd !== 32'hB0B0_0003) begin n_fail++; $display("FAIL b2b_readback: got %h expected b0b00003", rd); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic re; int lat;
        int pulses = 0;
        drive_a(1'b1, 1'b0, 2'b10, 1'b0, 32'h1000_0080, 32'd0);
        tick;
        drive_a(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (ia.req_ready !== 1'b0) begin n_fail++; $display("FAIL mid_wait_ready: got %b expected 0", ia.req_ready); end
        tick;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ia.rsp_valid !== 1'b0) pulses++;
            if (c == 0) begin
                n_cmp++; if (ia.req_ready !== 1'b1 || ia.rsp_err !== 1'b0 || ia.rsp_rdata !== 32'd0 ||
                             ia.mem_wen !== 4'b0000 || ia.mem_addr !== 32'd0) begin
                    n_fail++; $display("FAIL mid_reset_outputs: got ready %b err %b rdata %h wen %b addr %h expected 1 0 0 0000 0",
                                       ia.req_ready, ia.rsp_err, ia.rsp_rdata, ia.mem_wen, ia.mem_addr);
                end
            end
            tick;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL mid_reset_dropped: got %0d pulses expected 0", pulses); end
        load_a(2'b10, 1'b0, 32'h1000_0080, rd, re, lat);
        n_cmp++; if (rd !== 32'hB0B0_0000 || lat !== 2) begin
            n_fail++; $display("FAIL post_reset_load: got %h lat %0d expected b0b00000 2", rd, lat);
        end
    endtask

    task automatic test_latency2;
        ib.req_valid = 1'b1; ib.req_we = 1'b1; ib.req_size = 2'b10;
        ib.req_unsigned = 1'b0; ib.req_addr = 32'h1000_0040; ib.req_wdata = 32'h1122_3344;
        tick;
        ib.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ib.rsp_valid !== 1'b1 || ib.rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL l2_store_rsp: got valid %b err %b expected 1 0", ib.rsp_valid, ib.rsp_err);
        end
        tick;
        ib.req_valid = 1'b1; ib.req_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (ib.req_ready !== 1'b1) begin n_fail++; $display("FAIL l2_c0_ready: got %b expected 1", ib.req_ready); end
        tick;
        ib.req_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_cmp++; if (ib.req_ready !== 1'b0 || ib.rsp_valid !== 1'b0) begin
                n_fail++; $display("FAIL l2_c%0d_wait: got ready %b valid %b expected 0 0", c, ib.req_ready, ib.rsp_valid);
            end
            tick;
        end
        ib.req_valid = 1'b1; ib.req_we = 1'b1; ib.req_size = 2'b00;
        ib.req_addr = 32'h1000_0044; ib.req_wdata = 32'h0000_0077;
        @(negedge clk);
        n_cmp++; if (ib.rsp_valid !== 1'b1 || ib.rsp_rdata !== 32'h1122_3344) begin
            n_fail++; $display("FAIL l2_c3_rsp: got valid %b rdata %h expected 1 11223344", ib.rsp_valid, ib.rsp_rdata);
        end
        n_cmp++; if (ib.req_ready !== 1'b1 || ib.mem_wen !== 4'b0001) begin
            n_fail++; $display("FAIL l2_c3_accept: got ready %b wen %b expected 1 0001", ib.req_ready, ib.mem_wen);
        end
        tick;
        ib.req_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (ib.rsp_valid !== 1'b1 || ib.rsp_err !== 1'b0 || ib.rsp_rdata !== 32'd0) begin
            n_fail++; $display("FAIL l2_c4_store_rsp: got valid %b err %b rdata %h expected 1 0 0", ib.rsp_valid, ib.rsp_err, ib.rsp_rdata);
        end
        tick;
    endtask

    // run all scenarios in order and report
    initial begin
        test_reset;
        test_store_load_word;
        test_load_extend;
        test_store_lanes;
        test_errors;
        test_back_to_back;
        test_reset_mid;
        test_latency2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1);
    end
endmodule
